// File: rtl/vga_timing_controller.sv
// VGA raster timing with pixel-latency-matched sync, blanking and colour outputs.
// Optional colour-bar source enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_controller #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned PIX_LAT  = 1
) (
    input  logic        clk_vga,
    input  logic        reset,
    input  logic [11:0] pixel_data,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic [10:0] screen_row_address,
    output logic [10:0] screen_col_address,
    output logic        video_on,
    output logic        frame_start,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync
);

    localparam int unsigned CW      = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0]      h_next;
    logic [CW-1:0]      v_next;
    logic               hs_raw;
    logic               vs_raw;
    logic [PIX_LAT-1:0] hs_pipe;
    logic [PIX_LAT-1:0] vs_pipe;
    logic [PIX_LAT-1:0] von_pipe;
    logic [11:0]        colour;

    // Next raster position and undelayed sync decode of the current position
    always_comb begin
        h_next = (screen_col_address == H_LAST) ? '0 : screen_col_address + CW'(1);
        v_next = screen_row_address;
        if (screen_col_address == H_LAST) begin
            v_next = (screen_row_address == V_LAST) ? '0 : screen_row_address + CW'(1);
        end
        hs_raw = (screen_col_address >= HS_BEG && screen_col_address < HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_raw = (screen_row_address >= VS_BEG && screen_row_address < VS_END) ? SYNC_POL : ~SYNC_POL;
    end

    // video_on/frame_start are decoded from the next position so they line up with the addresses
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            screen_col_address <= '0;
            screen_row_address <= '0;
            video_on           <= 1'b1;
            frame_start        <= 1'b0;
        end else begin
            screen_col_address <= h_next;
            screen_row_address <= v_next;
            video_on           <= (h_next < H_VIS) && (v_next < V_VIS);
            frame_start        <= (h_next == '0) && (v_next == '0);
        end
    end

    // Delay line matching the pixel source latency
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            hs_pipe  <= {PIX_LAT{~SYNC_POL}};
            vs_pipe  <= {PIX_LAT{~SYNC_POL}};
            von_pipe <= '0;
        end else begin
            hs_pipe[0]  <= hs_raw;
            vs_pipe[0]  <= vs_raw;
            von_pipe[0] <= video_on;
            for (int i = 1; i < int'(PIX_LAT); i++) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                von_pipe[i] <= von_pipe[i-1];
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);

    logic [CW-1:0] col_pipe [PIX_LAT];
    logic [2:0]    bar;

    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(PIX_LAT); i++) begin
                col_pipe[i] <= '0;
            end
        end else begin
            col_pipe[0] <= screen_col_address;
            for (int i = 1; i < int'(PIX_LAT); i++) begin
                col_pipe[i] <= col_pipe[i-1];
            end
        end
    end

    // Bar index from the delayed column; colour packed as {B,G,R}
    always_comb begin
        bar    = 3'(col_pipe[PIX_LAT-1] / BAR_W);
        colour = pixel_data;
        if (test_pattern) begin
            colour = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
        end
    end
`else
    always_comb begin
        colour = pixel_data;
    end
`endif

    // Pin register: sync and colour leave together, colour forced to 0 outside the active area
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            hsync <= hs_pipe[PIX_LAT-1];
            vsync <= vs_pipe[PIX_LAT-1];
            if (von_pipe[PIX_LAT-1]) begin
                vga_r <= colour[3:0];
                vga_g <= colour[7:4];
                vga_b <= colour[11:8];
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: a full-size instance and a scaled-down instance
// (short frame, PIX_LAT=3) checked against an arithmetic raster model.
module tb_vga_timing_controller;

    localparam int F_SM = 80 * 19;

    logic        clk_vga = 1'b0;
    logic        reset;
    logic [11:0] pixel_data;
    bit          tp_mode;

    logic [10:0] b_row, b_col, s_row, s_col;
    logic        b_von, b_fs, b_hs, b_vs, s_von, s_fs, s_hs, s_vs;
    logic [3:0]  b_r, b_g, b_b, s_r, s_g, s_b;

    int          n;
    logic [11:0] cur_pd;
    int          checks;
    int          passed;

`ifdef VGA_TEST_PATTERN_EN
    logic test_pattern;
    assign test_pattern = tp_mode;
`endif

    always #20 clk_vga = ~clk_vga;

    vga_timing_controller u_big (
        .clk_vga(clk_vga), .reset(reset), .pixel_data(pixel_data),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .screen_row_address(b_row), .screen_col_address(b_col),
        .video_on(b_von), .frame_start(b_fs),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .hsync(b_hs), .vsync(b_vs)
    );

    vga_timing_controller #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b0), .PIX_LAT(3)
    ) u_small (
        .clk_vga(clk_vga), .reset(reset), .pixel_data(pixel_data),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .screen_row_address(s_row), .screen_col_address(s_col),
        .video_on(s_von), .frame_start(s_fs),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .hsync(s_hs), .vsync(s_vs)
    );

    logic [37:0] big_obs, small_obs;
    assign big_obs   = {b_row, b_col, b_von, b_fs, b_hs, b_vs, b_b, b_g, b_r};
    assign small_obs = {s_row, s_col, s_von, s_fs, s_hs, s_vs, s_b, s_g, s_r};

    // Expected observables n clock edges after reset release; pins show address n-lat-1
    function automatic logic [37:0] exp_obs(input bit sm, input int cyc, input logic [11:0] pd, input bit tp);
        int ht, ha, hfp, hsy, vt, va, vfp, vsy, lat, k, h, v, row, col;
        logic hs, vs, von, fs;
        logic [11:0] c;
        logic [2:0] bar;
        if (sm) begin
            ht = 80;  ha = 64;  hfp = 4;  hsy = 8;  vt = 19;  va = 12;  vfp = 2;  vsy = 2; lat = 3;
        end else begin
            ht = 800; ha = 640; hfp = 16; hsy = 96; vt = 525; va = 480; vfp = 10; vsy = 2; lat = 1;
        end
        col = cyc % ht;
        row = (cyc / ht) % vt;
        von = (col < ha) && (row < va);
        fs  = (cyc > 0) && (cyc % (ht * vt) == 0);
        hs  = 1'b1;
        vs  = 1'b1;
        c   = '0;
        k   = cyc - lat - 1;
        if (k >= 0) begin
            h  = k % ht;
            v  = (k / ht) % vt;
            hs = !(h >= ha + hfp && h < ha + hfp + hsy);
            vs = !(v >= va + vfp && v < va + vfp + vsy);
            if (h < ha && v < va) begin
                if (tp) begin
                    bar = 3'(h / (ha / 8));
                    c   = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
                end else begin
                    c = pd;
                end
            end
        end
        return {11'(row), 11'(col), von, fs, hs, vs, c};
    endfunction

    task automatic tick(input logic [11:0] pd);
        pixel_data = pd;
        cur_pd     = pd;
        @(posedge clk_vga);
        #1;
        n++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_vga);
        #1;
        reset = 1'b0;
        n     = 0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        pixel_data = 12'($urandom);
        #1;
        checks++;
        if (big_obs !== exp_obs(1'b0, 0, pixel_data, 1'b0))
            $display("FAIL reset_async_big got=%h exp=%h", big_obs, exp_obs(1'b0, 0, pixel_data, 1'b0));
        else passed++;
        checks++;
        if (small_obs !== exp_obs(1'b1, 0, pixel_data, 1'b0))
            $display("FAIL reset_async_small got=%h exp=%h", small_obs, exp_obs(1'b1, 0, pixel_data, 1'b0));
        else passed++;
        repeat (2) @(posedge clk_vga);
        #1;
        checks++;
        if (big_obs !== exp_obs(1'b0, 0, pixel_data, 1'b0))
            $display("FAIL reset_held_big got=%h exp=%h", big_obs, exp_obs(1'b0, 0, pixel_data, 1'b0));
        else passed++;
        checks++;
        if (small_obs !== exp_obs(1'b1, 0, pixel_data, 1'b0))
            $display("FAIL reset_held_small got=%h exp=%h", small_obs, exp_obs(1'b1, 0, pixel_data, 1'b0));
        else passed++;
        reset = 1'b0;
        n     = 0;
    endtask

    task automatic test_random_frames();
        int hlow = 0, hfall = 0, vlow = 0, vfall = 0, fs_cnt = 0;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        apply_reset();
        repeat (2 * F_SM + 200) begin
            tick(12'($urandom));
            checks++;
            if (big_obs !== exp_obs(1'b0, n, cur_pd, tp_mode))
                $display("FAIL random_big n=%0d got=%h exp=%h", n, big_obs, exp_obs(1'b0, n, cur_pd, tp_mode));
            else passed++;
            checks++;
            if (small_obs !== exp_obs(1'b1, n, cur_pd, tp_mode))
                $display("FAIL random_small n=%0d got=%h exp=%h", n, small_obs, exp_obs(1'b1, n, cur_pd, tp_mode));
            else passed++;
            if (n >= 1 && n <= F_SM && s_fs) fs_cnt++;
            if (n >= 4 && n <= F_SM + 3) begin
                if (!s_hs) hlow++;
                if (!s_hs && prev_hs) hfall++;
                if (!s_vs) vlow++;
                if (!s_vs && prev_vs) vfall++;
            end
            prev_hs = s_hs;
            prev_vs = s_vs;
        end
        checks++;
        if (fs_cnt !== 1) $display("FAIL frame_start_count got=%0d exp=1", fs_cnt); else passed++;
        checks++;
        if (hfall !== 19) $display("FAIL hsync_pulses got=%0d exp=19", hfall); else passed++;
        checks++;
        if (hlow !== 19 * 8) $display("FAIL hsync_low_cycles got=%0d exp=%0d", hlow, 19 * 8); else passed++;
        checks++;
        if (vfall !== 1) $display("FAIL vsync_pulses got=%0d exp=1", vfall); else passed++;
        checks++;
        if (vlow !== 2 * 80) $display("FAIL vsync_low_cycles got=%0d exp=%0d", vlow, 2 * 80); else passed++;
    endtask

    task automatic test_sync_edges();
        apply_reset();
        while (n < 656) tick(12'($urandom));
        checks++;
        if (b_col !== 11'd656) $display("FAIL sync_col656 got=%0d exp=656", b_col); else passed++;
        tick(12'($urandom));
        checks++;
        if (b_hs !== 1'b1) $display("FAIL hsync_fall_early got=%b exp=1", b_hs); else passed++;
        tick(12'($urandom));
        checks++;
        if (b_hs !== 1'b0) $display("FAIL hsync_fall got=%b exp=0", b_hs); else passed++;
        while (n < 752) tick(12'($urandom));
        checks++;
        if (b_col !== 11'd752) $display("FAIL sync_col752 got=%0d exp=752", b_col); else passed++;
        tick(12'($urandom));
        checks++;
        if (b_hs !== 1'b0) $display("FAIL hsync_rise_early got=%b exp=0", b_hs); else passed++;
        tick(12'($urandom));
        checks++;
        if (b_hs !== 1'b1) $display("FAIL hsync_rise got=%b exp=1", b_hs); else passed++;
    endtask

    task automatic test_blanking();
        logic [11:0] exp_b, exp_s;
        int kb, ks;
        apply_reset();
        repeat (F_SM + 10) begin
            tick(12'hABC);
            kb    = n - 2;
            ks    = n - 4;
            exp_b = (kb >= 0 && kb % 800 < 640 && (kb / 800) % 525 < 480) ? 12'hABC : 12'h000;
            exp_s = (ks >= 0 && ks % 80 < 64 && (ks / 80) % 19 < 12) ? 12'hABC : 12'h000;
            checks++;
            if ({b_b, b_g, b_r} !== exp_b)
                $display("FAIL blank_big n=%0d got=%h exp=%h", n, {b_b, b_g, b_r}, exp_b);
            else passed++;
            checks++;
            if ({s_b, s_g, s_r} !== exp_s)
                $display("FAIL blank_small n=%0d got=%h exp=%h", n, {s_b, s_g, s_r}, exp_s);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        while (n < 8 * 80 + 70) tick(12'($urandom));
        reset = 1'b1;
        #1;
        checks++;
        if (big_obs !== exp_obs(1'b0, 0, cur_pd, 1'b0))
            $display("FAIL midreset_big got=%h exp=%h", big_obs, exp_obs(1'b0, 0, cur_pd, 1'b0));
        else passed++;
        checks++;
        if (small_obs !== exp_obs(1'b1, 0, cur_pd, 1'b0))
            $display("FAIL midreset_small got=%h exp=%h", small_obs, exp_obs(1'b1, 0, cur_pd, 1'b0));
        else passed++;
        repeat (3) @(posedge clk_vga);
        #1;
        reset = 1'b0;
        n     = 0;
        repeat (2 * F_SM) begin
            tick(12'($urandom));
            checks++;
            if (big_obs !== exp_obs(1'b0, n, cur_pd, tp_mode))
                $display("FAIL after_reset_big n=%0d got=%h exp=%h", n, big_obs, exp_obs(1'b0, n, cur_pd, tp_mode));
            else passed++;
            checks++;
            if (small_obs !== exp_obs(1'b1, n, cur_pd, tp_mode))
                $display("FAIL after_reset_small n=%0d got=%h exp=%h", n, small_obs, exp_obs(1'b1, n, cur_pd, tp_mode));
            else passed++;
        end
    endtask

    task automatic test_frame_boundary();
        apply_reset();
        while (n < 12 * 80 - 1) tick(12'($urandom));
        checks++;
        if ({s_row, s_col} !== {11'd11, 11'd79})
            $display("FAIL last_active_line got=%0d,%0d exp=11,79", s_row, s_col);
        else passed++;
        tick(12'($urandom));
        checks++;
        if ({s_row, s_col, s_von} !== {11'd12, 11'd0, 1'b0})
            $display("FAIL first_blank_line got=%0d,%0d,%b exp=12,0,0", s_row, s_col, s_von);
        else passed++;
        while (n < F_SM - 1) tick(12'($urandom));
        checks++;
        if ({s_row, s_col, s_fs} !== {11'd18, 11'd79, 1'b0})
            $display("FAIL frame_last got=%0d,%0d,%b exp=18,79,0", s_row, s_col, s_fs);
        else passed++;
        tick(12'($urandom));
        checks++;
        if ({s_row, s_col, s_fs, s_von} !== {11'd0, 11'd0, 1'b1, 1'b1})
            $display("FAIL frame_wrap got=%0d,%0d,%b,%b exp=0,0,1,1", s_row, s_col, s_fs, s_von);
        else passed++;
        tick(12'($urandom));
        checks++;
        if ({s_col, s_fs} !== {11'd1, 1'b0})
            $display("FAIL frame_start_width got=%0d,%b exp=1,0", s_col, s_fs);
        else passed++;
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern_bars();
        tp_mode = 1'b1;
        apply_reset();
        repeat (810) begin
            tick(12'($urandom));
            checks++;
            if (big_obs !== exp_obs(1'b0, n, cur_pd, 1'b1))
                $display("FAIL pattern_big n=%0d got=%h exp=%h", n, big_obs, exp_obs(1'b0, n, cur_pd, 1'b1));
            else passed++;
            checks++;
            if (small_obs !== exp_obs(1'b1, n, cur_pd, 1'b1))
                $display("FAIL pattern_small n=%0d got=%h exp=%h", n, small_obs, exp_obs(1'b1, n, cur_pd, 1'b1));
            else passed++;
            if (n - 2 == 40) begin
                checks++;
                if ({b_b, b_g, b_r} !== 12'h000) $display("FAIL bar0_black got=%h exp=000", {b_b, b_g, b_r});
                else passed++;
            end
            if (n - 2 == 100) begin
                checks++;
                if ({b_b, b_g, b_r} !== 12'h00F) $display("FAIL bar1_red got=%h exp=00f", {b_b, b_g, b_r});
                else passed++;
            end
            if (n - 2 == 600) begin
                checks++;
                if ({b_b, b_g, b_r} !== 12'hFFF) $display("FAIL bar7_white got=%h exp=fff", {b_b, b_g, b_r});
                else passed++;
            end
        end
        tp_mode = 1'b0;
    endtask
`endif

    initial begin
        checks  = 0;
        passed  = 0;
        n       = 0;
        tp_mode = 1'b0;
        cur_pd  = '0;
        test_reset();
        test_random_frames();
        test_sync_edges();
        test_blanking();
        test_mid_reset();
        test_frame_boundary();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern_bars();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
